// File: rtl/mem_stage_sized.sv
// mem_stage_sized: MIPS memory stage with WB->M store-data forwarding and a
// byte-addressed data memory. Supports byte/half/word loads and stores,
// signed or unsigned sub-word loads, and a configurable access latency.
// The latency is covered by a stall handshake to the hazard unit.
// Misaligned or illegal-size requests are flagged and have no other effect.
module mem_stage_sized #(
  parameter int LEN_WORD          = 32,
  parameter int LEN_REG_FILE_ADDR = 5,
  parameter int DEPTH_WORDS       = 256,
  parameter int MEM_LATENCY       = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         forward_wb_m,
  input  logic                         mem_read,
  input  logic                         mem_write,
  input  logic [1:0]                   mem_size,
  input  logic                         mem_unsigned,
  input  logic [LEN_REG_FILE_ADDR-1:0] write_reg,
  input  logic [LEN_WORD-1:0]          alu_out,
  input  logic [LEN_WORD-1:0]          write_data_mem,
  input  logic [LEN_WORD-1:0]          write_data_reg_wb_m,
  output logic [LEN_WORD-1:0]          read_data_mem,
  output logic                         stall,
  output logic                         misaligned
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LEN_WORD-1:0] mem_q [DEPTH_WORDS];

  logic                reqAny;
  logic                isBad;
  logic                reqOk;
  logic                complete;
  logic                commit;
  logic [IDX_W-1:0]    wordIdx;
  logic [1:0]          lane;
  logic [LEN_WORD-1:0] oldWord;
  logic [LEN_WORD-1:0] storeData;
  logic [LEN_WORD-1:0] laneData;
  logic [LEN_WORD-1:0] mergedWord;
  logic [3:0]          byteEn;
  logic [7:0]          loadByte;
  logic [15:0]         loadHalf;
  logic [LEN_WORD-1:0] loadExt;
  logic                unused_bits;

  // The destination register only travels through for hazard tracking, and
  // address bits above the memory index wrap, so neither affects this stage.
  assign unused_bits = ^{write_reg, alu_out[LEN_WORD-1:IDX_W+2]};

  assign wordIdx   = alu_out[IDX_W+1:2];
  assign lane      = alu_out[1:0];
  assign oldWord   = mem_q[wordIdx];
  assign storeData = forward_wb_m ? write_data_reg_wb_m : write_data_mem;

  // Classify the request: a bad request is an illegal size or a sub-word
  // address that does not fit the natural alignment of the access.
  always_comb begin
    reqAny = mem_read | mem_write;
    isBad  = (mem_size == 2'b11)
           | ((mem_size == 2'b01) & lane[0])
           | ((mem_size == 2'b10) & (lane != 2'b00));
    reqOk  = reqAny & ~isBad;
    misaligned = reqAny & isBad & ~reset;
  end

  // Latency sequencer: stalls the pipeline for MEM_LATENCY-1 cycles and marks
  // the final cycle of an access as the completion cycle. Dropping the request
  // mid-access (flush) returns to IDLE without completing.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (reqOk) begin
          if (MEM_LATENCY > 1) begin
            stall   = 1'b1;
            cnt_d   = CNT_W'(1);
            state_d = WAIT;
          end else begin
            complete = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!reqOk) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST_CNT) begin
          complete = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (reset) begin
      stall    = 1'b0;
      complete = 1'b0;
    end
  end

  // Sequencer state register; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Extract and extend the load result; it is only driven during the
  // completion cycle of a read so the M/WB register sees zero otherwise.
  always_comb begin
    loadByte = oldWord[8*lane +: 8];
    loadHalf = lane[1] ? oldWord[31:16] : oldWord[15:0];
    case (mem_size)
      2'b00:   loadExt = mem_unsigned ? {{(LEN_WORD-8){1'b0}}, loadByte}
                                      : {{(LEN_WORD-8){loadByte[7]}}, loadByte};
      2'b01:   loadExt = mem_unsigned ? {{(LEN_WORD-16){1'b0}}, loadHalf}
                                      : {{(LEN_WORD-16){loadHalf[15]}}, loadHalf};
      default: loadExt = oldWord;
    endcase
    read_data_mem = (complete & mem_read) ? loadExt : '0;
  end

  // Build the byte enables and replicate store data across lanes so that
  // only the addressed bytes change and the rest of the word is preserved.
  always_comb begin
    byteEn = 4'b0000;
    case (mem_size)
      2'b00:   byteEn[lane] = 1'b1;
      2'b01:   byteEn = lane[1] ? 4'b1100 : 4'b0011;
      2'b10:   byteEn = 4'b1111;
      default: byteEn = 4'b0000;
    endcase
    case (mem_size)
      2'b00:   laneData = {4{storeData[7:0]}};
      2'b01:   laneData = {2{storeData[15:0]}};
      default: laneData = storeData;
    endcase
    for (int b = 0; b < 4; b++) begin
      mergedWord[8*b +: 8] = byteEn[b] ? laneData[8*b +: 8] : oldWord[8*b +: 8];
    end
    commit = complete & mem_write;
  end

  // Data memory: cleared by reset, written on the edge that ends the
  // completion cycle of a store. Reset wins over a simultaneous commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (commit) begin
      mem_q[wordIdx] <= mergedWord;
    end
  end

endmodule

// File: tb/tb_mem_stage_sized.sv
// tb_mem_stage_sized: exercises a single-cycle instance with a table of
// directed vectors and a three-cycle instance with hand-written sequences.
module tb_mem_stage_sized;

  logic        clk = 1'b0;
  logic        reset;
  logic        forward_wb_m;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [4:0]  write_reg;
  logic [31:0] alu_out;
  logic [31:0] write_data_mem;
  logic [31:0] write_data_reg_wb_m;

  logic [31:0] readData1, readData3;
  logic        stall1, stall3;
  logic        misaligned1, misaligned3;

  int checksDone   = 0;
  int checksPassed = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic        fwd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] wbdata;
    logic        chkRead;
    logic [31:0] expRead;
    logic        expMis;
  } vec_t;

  vec_t vecs[28];

  // Free-running clock shared by both instances.
  always #5 clk = ~clk;

  mem_stage_sized #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .forward_wb_m(forward_wb_m),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .write_reg(write_reg), .alu_out(alu_out),
    .write_data_mem(write_data_mem), .write_data_reg_wb_m(write_data_reg_wb_m),
    .read_data_mem(readData1), .stall(stall1), .misaligned(misaligned1)
  );

  mem_stage_sized #(.MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .forward_wb_m(forward_wb_m),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .write_reg(write_reg), .alu_out(alu_out),
    .write_data_mem(write_data_mem), .write_data_reg_wb_m(write_data_reg_wb_m),
    .read_data_mem(readData3), .stall(stall3), .misaligned(misaligned3)
  );

  function automatic vec_t mkVec(logic rd, logic wr, logic [1:0] size, logic uns,
                                 logic fwd, logic [31:0] addr, logic [31:0] wdata,
                                 logic [31:0] wbdata, logic chkRead,
                                 logic [31:0] expRead, logic expMis);
    vec_t v;
    v.rd = rd; v.wr = wr; v.size = size; v.uns = uns; v.fwd = fwd;
    v.addr = addr; v.wdata = wdata; v.wbdata = wbdata;
    v.chkRead = chkRead; v.expRead = expRead; v.expMis = expMis;
    return v;
  endfunction

  task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] size,
                               input logic uns, input logic fwd, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] wbdata);
    mem_read            = rd;
    mem_write           = wr;
    mem_size            = size;
    mem_unsigned        = uns;
    forward_wb_m        = fwd;
    alu_out             = addr;
    write_data_mem      = wdata;
    write_data_reg_wb_m = wbdata;
    write_reg           = 5'd7;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checksDone++;
    if (actual === expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  // One cycle on the three-cycle instance: sample mid-cycle, then advance.
  task automatic cycle3(input string tag, input logic expStall, input logic doRead,
                        input logic [31:0] expRead);
    @(negedge clk);
    checkOutput({tag, "_stall"}, {31'b0, stall3}, {31'b0, expStall});
    if (doRead) checkOutput({tag, "_read"}, readData3, expRead);
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            rd    wr    size   uns   fwd   addr          wdata         wbdata        chk   expRead       mis
    vecs[0]  = mkVec(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'h0,         1'b1, 32'h0000_0000, 1'b0);
    vecs[1]  = mkVec(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0, 32'h0,         1'b0);
    vecs[2]  = mkVec(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0);
    vecs[3]  = mkVec(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_0013, 32'h0,         32'h0,         1'b1, 32'hFFFF_FFDE, 1'b0);
    vecs[4]  = mkVec(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 32'h0000_0013, 32'h0,         32'h0,         1'b1, 32'h0000_00DE, 1'b0);
    vecs[5]  = mkVec(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 32'h0000_0012, 32'h0,         32'h0,         1'b1, 32'hFFFF_DEAD, 1'b0);
    vecs[6]  = mkVec(1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'h0,         1'b1, 32'h0000_BEEF, 1'b0);
    vecs[7]  = mkVec(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0000_0011, 32'hAAAA_AA55, 32'h0,         1'b0, 32'h0,         1'b0);
    vecs[8]  = mkVec(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'h0,         1'b1, 32'hDEAD_55EF, 1'b0);
    vecs[9]  = mkVec(1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 32'h0000_0012, 32'hFFFF_FFFF, 32'h0000_1234, 1'b0, 32'h0,         1'b0);
    vecs[10] = mkVec(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'h0,         1'b1, 32'h1234_55EF, 1'b0);
    vecs[11] = mkVec(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h0000_0012, 32'h0,         32'h0,         1'b1, 32'h0000_0000, 1'b1);
    vecs[12] = mkVec(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 32'h0000_0001, 32'h0,         32'h0,         1'b1, 32'h0000_0000, 1'b1);
    vecs[13] = mkVec(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'h0,         1'b1, 32'h0000_0000, 1'b1);
    vecs[14] = mkVec(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'h0,         1'b0, 32'h0,         1'b1);
    vecs[15] = mkVec(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0000_0011, 32'h0,         32'h0,         1'b0, 32'h0,         1'b1);
    vecs[16] = mkVec(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h0000_0013, 32'h0,         32'h0,         1'b0, 32'h0,         1'b1);
    vecs[17] = mkVec(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'h0,         1'b1, 32'h1234_55EF, 1'b0);
    vecs[18] = mkVec(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'h0,         1'b1, 32'hFFFF_FFEF, 1'b0);
    vecs[19] = mkVec(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_0011, 32'h0,         32'h0,         1'b1, 32'h0000_0055, 1'b0);
    vecs[20] = mkVec(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 32'h0000_0012, 32'h0,         32'h0,         1'b1, 32'h0000_1234, 1'b0);
    vecs[21] = mkVec(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0000_0400, 32'hA5A5_A5A5, 32'h0,         1'b0, 32'h0,         1'b0);
    vecs[22] = mkVec(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'h0,         1'b1, 32'hA5A5_A5A5, 1'b0);
    vecs[23] = mkVec(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'h0,         1'b1, 32'h1234_55EF, 1'b0);
    vecs[24] = mkVec(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0000_0010, 32'h0000_0077, 32'h0,         1'b1, 32'hFFFF_FFEF, 1'b0);
    vecs[25] = mkVec(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'h0,         1'b1, 32'h1234_5577, 1'b0);
    vecs[26] = mkVec(1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'h0,         1'b1, 32'h0000_0000, 1'b0);
    vecs[27] = mkVec(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_0012, 32'h0,         32'h0,         1'b1, 32'h0000_0034, 1'b0);

    // Reset state: outputs forced quiet even with a request presented.
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("rst_read1", readData1, 32'h0);
    checkOutput("rst_stall1", {31'b0, stall1}, 32'h0);
    checkOutput("rst_mis1", {31'b0, misaligned1}, 32'h0);
    checkOutput("rst_stall3", {31'b0, stall3}, 32'h0);
    alu_out = 32'h12;
    #1;
    checkOutput("rst_mis_bad", {31'b0, misaligned1}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single-cycle instance: table of directed vectors.
    for (int i = 0; i < 28; i++) begin
      applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].size, vecs[i].uns, vecs[i].fwd,
                    vecs[i].addr, vecs[i].wdata, vecs[i].wbdata);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_stall", i), {31'b0, stall1}, 32'h0);
      checkOutput($sformatf("vec%0d_mis", i), {31'b0, misaligned1}, {31'b0, vecs[i].expMis});
      if (vecs[i].chkRead) begin
        checkOutput($sformatf("vec%0d_read", i), readData1, vecs[i].expRead);
      end
      @(posedge clk);
      #1;
    end

    // Three-cycle instance: start from a clean memory.
    idleInputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h20, 32'hCAFE_F00D, 32'h0);
    cycle3("sw1_c1", 1'b1, 1'b0, 32'h0);
    cycle3("sw1_c2", 1'b1, 1'b0, 32'h0);
    cycle3("sw1_c3", 1'b0, 1'b0, 32'h0);

    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h20, 32'h0, 32'h0);
    cycle3("lw1_c1", 1'b1, 1'b1, 32'h0);
    cycle3("lw1_c2", 1'b1, 1'b1, 32'h0);
    cycle3("lw1_c3", 1'b0, 1'b1, 32'hCAFE_F00D);

    // Flush mid-access, then a full store must still take three cycles.
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h20, 32'h0, 32'h0);
    cycle3("flush_c1", 1'b1, 1'b0, 32'h0);
    idleInputs();
    cycle3("flush_idle", 1'b0, 1'b1, 32'h0);
    applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h24, 32'h0BAD_C0DE, 32'h0);
    cycle3("sw2_c1", 1'b1, 1'b0, 32'h0);
    cycle3("sw2_c2", 1'b1, 1'b0, 32'h0);
    cycle3("sw2_c3", 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h24, 32'h0, 32'h0);
    cycle3("lw2_c1", 1'b1, 1'b0, 32'h0);
    cycle3("lw2_c2", 1'b1, 1'b0, 32'h0);
    cycle3("lw2_c3", 1'b0, 1'b1, 32'h0BAD_C0DE);

    // Misaligned request on the multi-cycle instance never stalls.
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h22, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("lat3_mis", {31'b0, misaligned3}, 32'h1);
    cycle3("lat3_mis", 1'b0, 1'b1, 32'h0);

    // Reset during cycle 2 of a store aborts it.
    applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h20, 32'h1111_1111, 32'h0);
    cycle3("swrst_c1", 1'b1, 1'b0, 32'h0);
    reset = 1'b1;
    cycle3("swrst_c2", 1'b0, 1'b1, 32'h0);
    reset = 1'b0;
    idleInputs();
    cycle3("swrst_after", 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h20, 32'h0, 32'h0);
    cycle3("lw3_c1", 1'b1, 1'b0, 32'h0);
    cycle3("lw3_c2", 1'b1, 1'b0, 32'h0);
    cycle3("lw3_c3", 1'b0, 1'b1, 32'h0);
    idleInputs();

    $display("%0d/%0d checks passed", checksPassed, checksDone);
    $finish;
  end

endmodule
